// File: rtl/toggle_divider_bank.sv
// toggle_divider_bank: bank of independent programmable clock dividers with toggle and pulse outputs
module toggle_divider_bank #(
  parameter int CHANNELS = 4,
  parameter int DIV_W = 8,
  parameter int unsigned DIV_RST = 1,
  localparam int LW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] mode,
  input  logic                load,
  input  logic [LW-1:0]       load_ch,
  input  logic [DIV_W-1:0]    load_div,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] tick
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DIV_W-1:0] div_r, cnt_r;
    logic o, t, mq, ld, wrap;
    assign ld = load && int'(load_ch) == c;
    assign wrap = cnt_r == div_r;
    assign out[c] = o;
    assign tick[c] = t;
    always_ff @(posedge clk)
      if (!rst_n) begin
        div_r <= DIV_W'(DIV_RST);
        cnt_r <= '0;
        o <= 1'b0;
        t <= 1'b0;
        mq <= 1'b0;
      end else begin
        mq <= mode[c];
        if (ld || mode[c] != mq) begin
          if (ld) div_r <= load_div;
          cnt_r <= '0;
          o <= 1'b0;
          t <= 1'b0;
        end else if (en[c]) begin
          cnt_r <= wrap ? '0 : cnt_r + 1'b1;
          t <= wrap;
          o <= mq ? wrap : o ^ wrap;
        end else begin
          t <= 1'b0;
          o <= mq ? 1'b0 : o;
        end
      end
  end
endmodule

// File: tb/tb_toggle_divider_bank.sv
// tb_toggle_divider_bank: randomized and directed check against a phase-count reference model
module tb_toggle_divider_bank;
  localparam int CH = 5;
  localparam int DW = 4;
  localparam int LW = 3;
  logic clk = 0, rst_n = 0, load = 0;
  logic [CH-1:0] en = '1, mode = '0, out, tick;
  logic [LW-1:0] load_ch = '0;
  logic [DW-1:0] load_div = '0;
  int n_vec = 0, n_err = 0;
  int d[CH], ph[CH];
  bit mq[CH];
  logic [CH-1:0] eo, et;

  toggle_divider_bank #(.CHANNELS(CH), .DIV_W(DW), .DIV_RST(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .load_ch(load_ch), .load_div(load_div), .out(out), .tick(tick));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: ph counts enabled edges since the last restart; a wrap is every (d+1)-th one
  task automatic model();
    for (int c = 0; c < CH; c++) begin
      if (!rst_n) begin
        d[c] = 1; ph[c] = 0; mq[c] = 0; eo[c] = 0; et[c] = 0;
      end else begin
        bit ld, mc, w;
        ld = load && int'(load_ch) == c;
        mc = mode[c] != mq[c];
        mq[c] = mode[c];
        if (ld || mc) begin
          if (ld) d[c] = int'(load_div);
          ph[c] = 0; eo[c] = 0; et[c] = 0;
        end else if (en[c]) begin
          ph[c]++;
          w = ph[c] % (d[c] + 1) == 0;
          et[c] = w;
          eo[c] = mode[c] ? w : ((ph[c] / (d[c] + 1)) % 2 == 1);
        end else begin
          et[c] = 0;
          eo[c] = mode[c] ? 1'b0 : ((ph[c] / (d[c] + 1)) % 2 == 1);
        end
      end
    end
  endtask

  task automatic cyc(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      model();
      #1;
      chk("out", 32'(out), 32'(eo));
      chk("tick", 32'(tick), 32'(et));
      load = 0;
    end
  endtask

  task automatic do_load(input int ch, input int dv);
    load = 1; load_ch = LW'(ch); load_div = DW'(dv);
    cyc();
  endtask

  initial begin
    rst_n = 0; en = '1;
    cyc(3);
    chk("rst_out", 32'(out), 0);
    chk("rst_tick", 32'(tick), 0);
    rst_n = 1;
    cyc(12);
    do_load(2, 4);
    cyc(20);
    mode[1] = 1;
    do_load(1, 3);
    cyc(12);
    do_load(1, 0);
    cyc(5);
    do_load(0, 2);
    cyc(4);
    en[0] = 0;
    cyc(3);
    en[0] = 1;
    cyc(8);
    do_load(0, 2);
    cyc(2);
    do_load(0, 2);
    chk("ld_wrap_out0", 32'(out[0]), 0);
    cyc(4);
    mode[2] = 1;
    cyc(1);
    chk("mflip_out2", 32'(out[2]), 0);
    cyc(6);
    for (int j = CH; j < 8; j++) do_load(j, 9);
    cyc(4);
    mode = '0;
    do_load(3, 15);
    cyc(70);
    for (int i = 0; i < 2000; i++) begin
      rst_n = $urandom_range(0, 199) != 0;
      en = CH'($urandom) | CH'($urandom);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 15) == 0) mode[c] = ~mode[c];
      load = $urandom_range(0, 9) == 0;
      load_ch = LW'($urandom_range(0, 7));
      load_div = DW'($urandom_range(0, 3) == 0 ? 15 : $urandom);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
